// File: rtl/conv_pkg.sv
// Shared layout definitions for the line buffer, window generator and MAC array:
// kernel geometry, column/window packing index helpers and the generator FSM states.
package conv_pkg;

  localparam int K        = 3;
  localparam int WIN_TAPS = K * K;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Element index of (row, ch) inside a packed column beat.
  function automatic int col_idx(input int row, input int ch, input int p_ch);
    return row * p_ch + ch;
  endfunction

  // Element index of (ky, kx, ch) inside a packed window.
  function automatic int win_idx(input int ky, input int kx, input int ch, input int p_ch);
    return (ky * K + kx) * p_ch + ch;
  endfunction

endpackage

// File: rtl/conv_window_3x3_if.sv
// Column-in / window-out handshake bundle; slave is the window generator,
// master is the surrounding logic (line buffer upstream, MAC array downstream).
interface conv_window_3x3_if #(
  parameter int DWIDTH = 8,
  parameter int P_CH   = 32
);
  import conv_pkg::*;

  logic                             col_valid;
  logic                             col_ready;
  logic [K*P_CH*DWIDTH-1:0]         col_data;
  logic                             col_sol;
  logic                             col_eol;
  logic                             win_valid;
  logic                             win_ready;
  logic [WIN_TAPS*P_CH*DWIDTH-1:0]  win_data;
  logic                             win_sol;
  logic                             win_eol;

  modport slave (
    input  col_valid, col_data, col_sol, col_eol, win_ready,
    output col_ready, win_valid, win_data, win_sol, win_eol
  );

  modport master (
    output col_valid, col_data, col_sol, col_eol, win_ready,
    input  col_ready, win_valid, win_data, win_sol, win_eol
  );
endinterface

// File: rtl/conv_col_shreg.sv
// Three-column shift register feeding the window; zero_i clears the middle slot
// during a shift so the column entering at start-of-line sees a zero left neighbour.
module conv_col_shreg
  import conv_pkg::*;
#(
  parameter int CW = 768
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift_i,
  input  logic          zero_i,
  input  logic [CW-1:0] col_i,
  output logic [CW-1:0] col_o [K]
);

  logic [CW-1:0] col_q [K];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < K; i++) col_q[i] <= '0;
    end else if (shift_i) begin
      for (int i = 0; i < K - 1; i++)
        col_q[i] <= (zero_i && i == K - 2) ? '0 : col_q[i+1];
      col_q[K-1] <= col_i;
    end
  end

  for (genvar gi = 0; gi < K; gi++) begin : g_out
    assign col_o[gi] = col_q[gi];
  end

endmodule

// File: rtl/conv_window_3x3.sv
// 3x3xP_CH sliding-window generator behind the line buffer. Define
// CONV_WIN_ZERO_PAD_EN for same-size output with one zero column of padding each side.
module conv_window_3x3
  import conv_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int P_CH   = 32,
  parameter int IMG_W  = 224
) (
  input  logic                clk,
  input  logic                rst,
  conv_window_3x3_if.slave    bus,
  output logic                line_short_err
);

  localparam int CW = K * P_CH * DWIDTH;
  localparam int XW = $clog2(IMG_W + 1);
  localparam logic [XW-1:0] CNT_MAX = XW'(2);
`ifdef CONV_WIN_ZERO_PAD_EN
  localparam logic [XW-1:0] CNT_WIN = XW'(1);
`else
  localparam logic [XW-1:0] CNT_WIN = XW'(2);
`endif

  logic [XW-1:0] cnt_q, cnt_d;
  logic          win_valid_q, win_sol_q, win_eol_q, err_q;
  logic          run_ready, col_acc, col_load, win_load;
  logic          flush_active, flush_load, zero_col;
  logic          sol_next, eol_next;
  logic [CW-1:0] shift_in;
  logic [CW-1:0] cols [K];

  assign run_ready     = !win_valid_q || bus.win_ready;
  assign bus.col_ready = !rst && !flush_active && run_ready;
  assign col_acc       = bus.col_valid && bus.col_ready;

  // cnt = accepted columns in this line minus one, saturating at 2
  always_comb begin
    cnt_d = cnt_q;
    if (col_acc) begin
      if (bus.col_sol)         cnt_d = '0;
      else if (cnt_q >= CNT_MAX) cnt_d = CNT_MAX;
      else                     cnt_d = cnt_q + XW'(1);
    end
  end

  assign col_load = col_acc && (cnt_d >= CNT_WIN);
  assign win_load = col_load || flush_load;

`ifdef CONV_WIN_ZERO_PAD_EN
  state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (col_acc && bus.col_eol && cnt_d >= CNT_WIN) state_d = ST_FLUSH;
      ST_FLUSH: if (run_ready) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // The flush shifts a zero column in, leaving {last-1, last, 0} in the register.
  always_comb begin
    flush_active = (state_q == ST_FLUSH);
    flush_load   = flush_active && run_ready;
    zero_col     = bus.col_sol && !flush_active;
    shift_in     = flush_active ? '0 : bus.col_data;
    sol_next     = !flush_active && (cnt_d == CNT_WIN);
    eol_next     = flush_active;
  end
`else
  always_comb begin
    flush_active = 1'b0;
    flush_load   = 1'b0;
    zero_col     = 1'b0;
    shift_in     = bus.col_data;
    sol_next     = (cnt_q != CNT_MAX);
    eol_next     = bus.col_eol;
  end
`endif

  conv_col_shreg #(.CW(CW)) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .shift_i (col_acc || flush_load),
    .zero_i  (zero_col),
    .col_i   (shift_in),
    .col_o   (cols)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      win_valid_q <= 1'b0;
      win_sol_q   <= 1'b0;
      win_eol_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (col_acc && bus.col_eol && cnt_d < CNT_WIN) err_q <= 1'b1;
      if (win_load) begin
        win_valid_q <= 1'b1;
        win_sol_q   <= sol_next;
        win_eol_q   <= eol_next;
      end else if (bus.win_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

  // The shift register only moves on a load while the output is free, so it
  // doubles as the held window data during a stall.
  for (genvar gi = 0; gi < K; gi++) begin : g_ky
    for (genvar gj = 0; gj < K; gj++) begin : g_kx
      for (genvar gk = 0; gk < P_CH; gk++) begin : g_ch
        localparam int WI = win_idx(gi, gj, gk, P_CH);
        localparam int CI = col_idx(gi, gk, P_CH);
        assign bus.win_data[WI*DWIDTH +: DWIDTH] = cols[gj][CI*DWIDTH +: DWIDTH];
      end
    end
  end

  assign bus.win_valid  = win_valid_q;
  assign bus.win_sol    = win_sol_q;
  assign bus.win_eol    = win_eol_q;
  assign line_short_err = err_q;

endmodule

// File: doc/conv_window_3x3.md
Name: conv_window_3x3

Overview:
- Sliding-window generator directly downstream of the BRAM line buffer.
- The line buffer presents one column per beat: the same x position from three vertically adjacent rows (r-2, r-1, r), each P_CH channels wide.
- This block builds 3x3xP_CH windows from successive columns and hands them to the convolution datapath over a valid/ready handshake.

Parameters:
- DWIDTH, 8, bits per channel sample.
- P_CH, 32, channels processed in parallel.
- IMG_W, 224, max line width in columns; sizes the column counter.
- XW, $clog2(IMG_W+1), column counter width (localparam).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- col_valid  in  1  column beat valid.
- col_ready  out  1  column beat accepted when col_valid && col_ready.
- col_data  in  3*P_CH*DWIDTH  packed as [row][ch]; row 0 = r-2 at LSBs, ch 0 lowest within each row.
- col_sol  in  1  beat is first column of a line.
- col_eol  in  1  beat is last column of a line.
- win_valid  out  1  window valid.
- win_ready  in  1  downstream accept.
- win_data  out  9*P_CH*DWIDTH  element (ky*3+kx)*P_CH+ch; kx=0 is oldest (leftmost) column, ky=0 is row r-2.
- win_sol  out  1  first window of a line.
- win_eol  out  1  last window of a line.
- line_short_err  out  1  sticky: a line ended before enough columns arrived to emit a window.

Behaviour:
- Reset: win_valid=0, win_data=0, win_sol=0, win_eol=0, line_short_err=0, col_ready=0 while rst is high. Shift register and counter are cleared; FSM returns to RUN.
- Output stage is a single register. col_ready = (!win_valid || win_ready) in RUN; col_ready = 0 in FLUSH.
- Full throughput: a window can be consumed and a new column accepted in the same cycle with no bubble.
- Shift register of three columns c0 (oldest), c1, c2. On each accepted column: c0<=c1, c1<=c2, c2<=col_data.
- On col_sol the counter restarts: the beat counts as column 0, and stale columns from the previous line never reach a window.
- Column counter cnt saturates at 2. cnt counts accepted columns in the current line, minus one, saturating.
- No-pad mode (macro off):
  - A window is loaded the cycle after accepting a column with cnt (post-update) == 2. win_data = {c0, c1, new column}. Latency is 1 cycle.
  - Windows per line = W-2.
  - win_sol is set on the first window of the line (the column with cnt first reaching 2).
  - win_eol = col_eol of the completing column.
- Short line: col_eol accepted with cnt < 2. No window is produced, line_short_err is set to 1 and stays set until rst, and the FSM stays in RUN.
- col_sol && col_eol on one beat is a short line (same handling).
- FSM states:
  - RUN: normal operation.
  - FLUSH: pad feature only. One cycle of output production, no input accepted.
  - FLUSH -> RUN once the flush window has been loaded into the output register (requires !win_valid || win_ready).
- Held output is stable while win_valid && !win_ready. No data change is allowed while stalled.

Optional Feature:
- Macro CONV_WIN_ZERO_PAD_EN.
- Defined: same-size convolution with 1-column zero padding left and right.
  - On col_sol, c1 is treated as zero (left pad), so the window centered on column 0 is emitted when column 1 arrives.
  - On accepting col_eol, the FSM enters FLUSH and emits the window centered on the last column with a zero right column and win_eol=1.
  - The col_eol beat's own window does not assert win_eol.
  - Windows per line = W.
  - Short-line threshold becomes W<2: a single-column line sets line_short_err and emits nothing.
- Undefined: no FLUSH state is synthesized, valid-only behaviour as above.

Decomposition:
- Shared package conv_pkg holds:
  - K=3 and WIN_TAPS=9.
  - The column/window packing index functions (col_idx(row,ch), win_idx(ky,kx,ch)), so the line buffer, this block and the MAC array agree on layout.
  - The FSM state enum {ST_RUN, ST_FLUSH}.
- One natural sub-module: conv_col_shreg, the 3-column shift register with synchronous zero-clear used for padding. Counter, FSM and handshake stay in the top.

Test Plan:
- P_CH=1, DWIDTH=8. Send the 5-column line col_data row-wise {x, 10+x, 20+x} for x=0..4, win_ready=1 -> 3 windows. The first is {0,1,2 / 10,11,12 / 20,21,22} with win_sol=1; the third has win_eol=1; col_ready stays 1.
- Same line with win_ready toggling 0/1 every cycle -> identical 3 windows in order. win_data is stable while stalled; no beat is lost or duplicated.
- Line of 2 columns (col_eol on x=1) -> no win_valid and line_short_err=1. The next 5-column line still produces 3 correct windows.
- Assert rst for 1 cycle after column 3 of a line -> all outputs 0 immediately. The following fresh line behaves like the first scenario.
- CONV_WIN_ZERO_PAD_EN defined, 5-column line -> 5 windows.
  - First window: {0,0,1 / 0,10,11 / 0,20,21}, win_sol=1.
  - Last window: {3,4,0 / 13,14,0 / 23,24,0}, win_eol=1.
  - col_ready=0 exactly during the FLUSH cycle.
- Back-to-back lines with no gap, win_ready=1 -> the second line's first window is not polluted by first-line columns, and throughput is 1 window per accepted column.
